mxu_feeder: RTL and testbench
=============================

# mxu_feeder

Sequencer that drives the 2x2 systolic MXU. It accepts one pair of operand matrices A and B over a valid/ready handshake, clears the MXU accumulators, and streams diagonally skewed, zero-padded operands into the MXU's west and north edges under a `ce` window. It then captures the MXU result matrix C = A·B and returns it over a second valid/ready handshake. It sits between the accelerator's operand buffers and the `mxu` instance.

## Interface
Parameters:
- `NUM_SIZE`, 16: element width in bits.
- `GRID_SIZE`, 2: array dimension. Only 2 is supported in this revision, and the skew schedule below is written for 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  feeder can accept an operand pair.
- `a_in`  in  64  A matrix; `a_in[(i*2+k)*16 +: 16]` = A[i][k].
- `b_in`  in  64  B matrix; `b_in[(k*2+j)*16 +: 16]` = B[k][j].
- `mxu_clr`  out  1  one-cycle accumulator clear; drives the MXU `rst`.
- `mxu_ce`  out  1  MXU clock enable.
- `mxu_west`  out  32  lane i = `[(i+1)*16-1:i*16]`; drives the MXU `west_input`.
- `mxu_north`  out  32  lane j; drives the MXU `north_input`.
- `mxu_result`  in  64  MXU `result_out`; `[(i*2+j)*16 +: 16]` = C[i][j].
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `c_out`  out  64  captured C, same packing as `mxu_result`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- MXU contract:
  - On each `clk` edge with `ce` high, every MAC adds `north_in*west_in`, truncated to 16 bits, into its accumulator.
  - On the same edge, every MAC registers its operands onward, south and east.
  - `rst` high zeroes all MACs.
  - Consequence: PE(i,j) sees operand index k at stream step t = k+i+j.
- FSM states: IDLE, CLEAR, STREAM, CAPTURE, OUTPUT. A 2-bit step counter `t` is used in STREAM.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a_in`/`b_in` into internal registers, then go to CLEAR.
- CLEAR: `mxu_clr`=1 for exactly one cycle; `t`<=0; go to STREAM.
- STREAM (4 cycles, t=0..3):
  - `mxu_ce`=1.
  - West lane i = A[i][t-i] when 0 ≤ t-i ≤ 1, else 0.
  - North lane j = B[t-j][j] when 0 ≤ t-j ≤ 1, else 0.
  - After t=3, go to CAPTURE.
- CAPTURE: `mxu_ce`=0; `c_out`<=`mxu_result`; go to OUTPUT.
- OUTPUT:
  - `out_valid`=1; `c_out` is held stable.
  - On `out_ready`, go to IDLE.
  - `out_valid` never drops without a handshake.
- `mxu_west`/`mxu_north` are 0 outside STREAM. `mxu_ce` is 0 outside STREAM.
- Arithmetic is entirely in the MXU, modulo 2^16. The feeder performs no arithmetic on data.
- `in_valid` outside IDLE is ignored (`in_ready`=0). Exactly one job is in flight at a time.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `busy`=0, `mxu_clr`=0, `mxu_ce`=0, `mxu_west`=0, `mxu_north`=0, `out_valid`=0, `c_out`=0, `t`=0.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Accept edge E0:
  - E0+1 cycle: CLEAR.
  - Cycles 2–5: STREAM.
  - Cycle 6: CAPTURE.
  - `out_valid` rises in cycle 7.
- Minimum job period is 8 cycles, when `out_ready` is held high.
- `rst` asserted mid-operation:
  - Immediate return to IDLE with reset values.
  - The partial result is discarded.
  - `mxu_clr` is not required to pulse on reset; the MXU shares `rst` upstream.
- `out_ready` held low: remain in OUTPUT indefinitely, with no MXU activity.

## Test plan
- Example product: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> `c_out`=[[19,22],[43,50]].
  - `out_valid` rises exactly 7 cycles after the accept edge.
- Skew check on the same job, per STREAM cycle, as (west lane0, lane1) / (north lane0, lane1):
  - t0: west=(1,0), north=(5,0).
  - t1: west=(2,3), north=(7,6).
  - t2: west=(0,4), north=(0,8).
  - t3: all zero.
  - `mxu_clr` pulses exactly once, before t0.
- Overflow: A=[[0x8000,0],[0,1]], B=[[2,0],[0,0xFFFF]] -> C=[[0x0000,0],[0,0xFFFF]].
- Backpressure and busy:
  - Hold `out_ready`=0 for 10 cycles -> `out_valid` and `c_out` are stable, `mxu_ce`=0, `in_ready`=0.
  - A second `in_valid` during that time is not accepted.
  - Release -> IDLE next cycle, and the second job then completes correctly with the accumulators cleared.
- Reset mid-STREAM: assert `rst` at t=2 -> all outputs are at reset values immediately.
  - A following identity-times-B job returns C=B.

Source files
------------

// File: rtl/mxu_feeder.sv
// Sequencer for the 2x2 systolic MXU: accepts one A/B operand pair, clears the array,
// streams skewed zero-padded operands under ce, then captures and returns C = A*B.
module mxu_feeder #(
   parameter int NUM_SIZE  = 16,
   parameter int GRID_SIZE = 2
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0] a_in,
   input  logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0] b_in,
   output logic                                   mxu_clr,
   output logic                                   mxu_ce,
   output logic [GRID_SIZE*NUM_SIZE-1:0]           mxu_west,
   output logic [GRID_SIZE*NUM_SIZE-1:0]           mxu_north,
   input  logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0] mxu_result,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [GRID_SIZE*GRID_SIZE*NUM_SIZE-1:0] c_out,
   output logic                                   busy
);

   localparam int MAT_W = GRID_SIZE * GRID_SIZE * NUM_SIZE;
   // The deepest PE sees its last operand at step 2*(GRID_SIZE-1)+1.
   localparam logic [1:0] LAST_STEP = 2'(2 * GRID_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      STREAM,
      CAPTURE,
      OUTPUT
   } state_t;

   state_t state;
   state_t next_state;

   logic [1:0]       t;
   logic [MAT_W-1:0] a_reg;
   logic [MAT_W-1:0] b_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid) next_state = CLEAR;
         CLEAR:   next_state = STREAM;
         STREAM:  if (t == LAST_STEP) next_state = CAPTURE;
         CAPTURE: next_state = OUTPUT;
         OUTPUT:  if (out_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Operands are latched once at accept; c_out only changes in CAPTURE so it holds through OUTPUT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         c_out <= '0;
         t     <= '0;
      end else begin
         if (state == IDLE && in_valid) begin
            a_reg <= a_in;
            b_reg <= b_in;
         end
         if (state == CLEAR) begin
            t <= '0;
         end else if (state == STREAM) begin
            t <= t + 2'd1;
         end
         if (state == CAPTURE) begin
            c_out <= mxu_result;
         end
      end
   end

   always_comb begin
      int k;
      k         = 0;
      in_ready  = 1'b0;
      mxu_clr   = 1'b0;
      mxu_ce    = 1'b0;
      mxu_west  = '0;
      mxu_north = '0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE:    in_ready = 1'b1;
         CLEAR:   mxu_clr = 1'b1;
         STREAM: begin
            mxu_ce = 1'b1;
            // Lane i carries operand index k = t - i, zero when k falls outside the matrix.
            for (int i = 0; i < GRID_SIZE; i++) begin
               k = int'(t) - i;
               if (k >= 0 && k < GRID_SIZE) begin
                  mxu_west[i*NUM_SIZE +: NUM_SIZE]  = a_reg[(i*GRID_SIZE + k)*NUM_SIZE +: NUM_SIZE];
                  mxu_north[i*NUM_SIZE +: NUM_SIZE] = b_reg[(k*GRID_SIZE + i)*NUM_SIZE +: NUM_SIZE];
               end
            end
         end
         OUTPUT:  out_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mxu_feeder.sv
// Self-checking bench for mxu_feeder with a behavioural 2x2 systolic MXU attached.
module tb_mxu_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] a_in;
   logic [63:0] b_in;
   logic        mxu_clr;
   logic        mxu_ce;
   logic [31:0] mxu_west;
   logic [31:0] mxu_north;
   logic [63:0] mxu_result;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] c_out;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   mxu_feeder #(.NUM_SIZE(16), .GRID_SIZE(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .mxu_clr    (mxu_clr),
      .mxu_ce     (mxu_ce),
      .mxu_west   (mxu_west),
      .mxu_north  (mxu_north),
      .mxu_result (mxu_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .c_out      (c_out),
      .busy       (busy)
   );

   // Behavioural MXU: west flows east, north flows south, one register per PE.
   logic [15:0] acc  [2][2];
   logic [15:0] wreg [2][2];
   logic [15:0] nreg [2][2];

   function automatic logic [15:0] west_at(int i, int j);
      if (j == 0) return mxu_west[i*16 +: 16];
      return wreg[i][j-1];
   endfunction

   function automatic logic [15:0] north_at(int i, int j);
      if (i == 0) return mxu_north[j*16 +: 16];
      return nreg[i-1][j];
   endfunction

   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            if (rst || mxu_clr) begin
               acc[i][j]  <= '0;
               wreg[i][j] <= '0;
               nreg[i][j] <= '0;
            end else if (mxu_ce) begin
               acc[i][j]  <= acc[i][j] + 16'(west_at(i, j) * north_at(i, j));
               wreg[i][j] <= west_at(i, j);
               nreg[i][j] <= north_at(i, j);
            end
         end
      end
   end

   assign mxu_result = {acc[1][1], acc[1][0], acc[0][1], acc[0][0]};

   function automatic logic [63:0] pack4(logic [15:0] e00, logic [15:0] e01,
                                         logic [15:0] e10, logic [15:0] e11);
      return {e11, e10, e01, e00};
   endfunction

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drives one accept and waits (bounded) for out_valid; lat counts edges after the accept edge.
   task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] c, output int lat);
      check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1;
      a_in     = a;
      b_in     = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a_in     = '0;
      b_in     = '0;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      c = c_out;
   endtask

   task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp,
                               input int lat);
      check({tag, "_c"}, got, exp);
      check({tag, "_latency"}, 64'(lat), 64'd7);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_out_valid_dropped"}, {63'd0, out_valid}, 64'd0);
      check({tag, "_idle_in_ready"}, {63'd0, in_ready}, 64'd1);
      check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
   endtask

   logic [63:0] got;
   int          lat;
   int          clr_pulses;
   logic [31:0] exp_w   [7];
   logic [31:0] exp_n   [7];
   logic        exp_ce  [7];
   logic        exp_clr [7];

   initial begin
      vecs[0] = '{pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(19, 22, 43, 50)};
      vecs[1] = '{pack4(16'h8000, 0, 0, 1), pack4(2, 0, 0, 16'hFFFF), pack4(0, 0, 0, 16'hFFFF)};
      vecs[2] = '{pack4(1, 0, 0, 1), pack4(9, 10, 11, 12), pack4(9, 10, 11, 12)};
      vecs[3] = '{pack4(2, 0, 0, 3), pack4(4, 5, 6, 7), pack4(8, 10, 18, 21)};
      vecs[4] = '{pack4(16'hFFFF, 1, 1, 1), pack4(1, 1, 1, 16'hFFFF), pack4(0, 16'hFFFE, 2, 0)};

      exp_w   = '{32'h0, 32'h0000_0001, 32'h0003_0002, 32'h0004_0000, 32'h0, 32'h0, 32'h0};
      exp_n   = '{32'h0, 32'h0000_0005, 32'h0006_0007, 32'h0008_0000, 32'h0, 32'h0, 32'h0};
      exp_ce  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_clr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a_in      = '0;
      b_in      = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check("rst_ce_clr", {62'd0, mxu_ce, mxu_clr}, 64'd0);
      check("rst_west_north", {mxu_north, mxu_west}, 64'd0);
      check("rst_c_out", c_out, 64'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int v = 0; v < 5; v++) begin
         apply_stimulus(vecs[v].a, vecs[v].b, got, lat);
         check_output($sformatf("vec%0d", v), got, vecs[v].c, lat);
      end

      // Per-cycle skew of the example job, cycle c after the accept edge.
      clr_pulses = 0;
      in_valid = 1'b1;
      a_in     = vecs[0].a;
      b_in     = vecs[0].b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int c = 1; c <= 7; c++) begin
         if (c > 1) begin
            @(posedge clk);
            #1;
         end
         if (mxu_clr) clr_pulses++;
         check($sformatf("skew_c%0d_west", c), {32'd0, mxu_west}, {32'd0, exp_w[c-1]});
         check($sformatf("skew_c%0d_north", c), {32'd0, mxu_north}, {32'd0, exp_n[c-1]});
         check($sformatf("skew_c%0d_ce", c), {63'd0, mxu_ce}, {63'd0, exp_ce[c-1]});
         check($sformatf("skew_c%0d_clr", c), {63'd0, mxu_clr}, {63'd0, exp_clr[c-1]});
         check($sformatf("skew_c%0d_out_valid", c), {63'd0, out_valid}, (c == 7) ? 64'd1 : 64'd0);
      end
      check("skew_clr_pulses", 64'(clr_pulses), 64'd1);
      check_output("skew", c_out, vecs[0].c, 7);

      // Backpressure: hold the result while a competing request is offered.
      apply_stimulus(vecs[3].a, vecs[3].b, got, lat);
      check("bp_c", got, vecs[3].c);
      check("bp_latency", 64'(lat), 64'd7);
      in_valid = 1'b1;
      a_in     = vecs[4].a;
      b_in     = vecs[4].b;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check("bp_out_valid", {63'd0, out_valid}, 64'd1);
         check("bp_c_stable", c_out, vecs[3].c);
         check("bp_ce_ready", {62'd0, mxu_ce, in_ready}, 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_idle", {62'd0, in_ready, out_valid}, 64'd2);
      apply_stimulus(vecs[0].a, vecs[0].b, got, lat);
      check_output("bp_second", got, vecs[0].c, lat);

      // Reset in the t=2 STREAM cycle, then an identity job.
      in_valid = 1'b1;
      a_in     = vecs[4].a;
      b_in     = vecs[4].b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_stream_ce", {63'd0, mxu_ce}, 64'd1);
      check("mid_stream_t2_west", {32'd0, mxu_west}, {32'd0, 16'h0001, 16'h0000});
      rst = 1'b1;
      #1;
      check("midrst_in_ready_busy", {62'd0, in_ready, busy}, 64'd2);
      check("midrst_ce_clr_valid", {61'd0, mxu_ce, mxu_clr, out_valid}, 64'd0);
      check("midrst_west_north", {mxu_north, mxu_west}, 64'd0);
      check("midrst_c_out", c_out, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      apply_stimulus(vecs[2].a, vecs[2].b, got, lat);
      check_output("post_rst_identity", got, vecs[2].b, lat);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
